// File: rtl/fir_pkg.sv
// Shared helpers for the transposed FIR: address/accumulator sizing and the
// constants that drive the round-half-up step of the output stage.
package fir_pkg;

  // Ceiling log2, loop-bounded so it elaborates as a constant function.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  // Full-precision accumulator width: product width plus growth for the tap sum.
  function automatic int acc_width(input int din_w, input int tap_w, input int taps);
    return din_w + tap_w + clog2(taps);
  endfunction

  // Rounding adds half an output LSB, which only exists when something is shifted out.
  function automatic bit rnd_en(input int out_shift);
    return out_shift > 0;
  endfunction

  function automatic int rnd_pos(input int out_shift);
    return (out_shift > 0) ? out_shift - 1 : 0;
  endfunction

endpackage

// File: rtl/fir_tap.sv
// One transposed-FIR cell: o_z <= i_x*i_h + i_z when i_en, zeroed by i_clr.
// Ports: clk/reset_n (async low), i_en advance, i_clr sync flush,
//        i_x sample, i_h coefficient, i_z partial sum from the next tap, o_z this tap's sum.
module fir_tap #(
  parameter int DIN_W = 16,
  parameter int TAP_W = 16,
  parameter int ACC_W = 35
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    i_en,
  input  logic                    i_clr,
  input  logic signed [DIN_W-1:0] i_x,
  input  logic signed [TAP_W-1:0] i_h,
  input  logic signed [ACC_W-1:0] i_z,
  output logic signed [ACC_W-1:0] o_z
);

  logic signed [DIN_W+TAP_W-1:0] w_prod;
  logic signed [ACC_W-1:0]       r_z;

  assign w_prod = i_x * i_h;
  assign o_z    = r_z;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   r_z <= '0;
    else if (i_clr) r_z <= '0;
    else if (i_en)  r_z <= ACC_W'(w_prod) + i_z;
  end

endmodule

// File: rtl/fir_transposed_cfg.sv
// Transposed-form FIR with runtime-writable coefficients.
// Ports: clk, reset_n (async low), clear (sync pipeline flush, coefs kept),
//        in_valid/in_data sample input, coef_wr_en/coef_addr/coef_data coefficient write,
//        out_valid/out_data/sat_flag registered result one cycle after an accepted sample.
module fir_transposed_cfg
  import fir_pkg::*;
#(
  parameter int DATA_IN_WIDTH  = 16,
  parameter int TAP_WIDTH      = 16,
  parameter int TAP_COUNT      = 8,
  parameter int DATA_OUT_WIDTH = 16,
  parameter int OUT_SHIFT      = 15,
  localparam int ADDR_W        = clog2(TAP_COUNT),
  localparam int ACC_WIDTH     = acc_width(DATA_IN_WIDTH, TAP_WIDTH, TAP_COUNT)
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             clear,
  input  logic                             in_valid,
  input  logic signed [DATA_IN_WIDTH-1:0]  in_data,
  input  logic                             coef_wr_en,
  input  logic [ADDR_W-1:0]                coef_addr,
  input  logic signed [TAP_WIDTH-1:0]      coef_data,
  output logic                             out_valid,
  output logic signed [DATA_OUT_WIDTH-1:0] out_data,
  output logic                             sat_flag
);

  // One guard bit so the rounding add cannot wrap.
  localparam int SW = ACC_WIDTH + 1;
  localparam logic [SW-1:0] RND = rnd_en(OUT_SHIFT) ? (SW'(1) << rnd_pos(OUT_SHIFT)) : '0;
  localparam logic [DATA_OUT_WIDTH-1:0] SAT_POS = {1'b0, {(DATA_OUT_WIDTH-1){1'b1}}};
  localparam logic [DATA_OUT_WIDTH-1:0] SAT_NEG = {1'b1, {(DATA_OUT_WIDTH-1){1'b0}}};

  logic [TAP_COUNT-1:0][TAP_WIDTH-1:0] r_coef;
  logic [TAP_COUNT:1][ACC_WIDTH-1:0]   w_z;
  logic                                w_acc;
  logic signed [DATA_IN_WIDTH+TAP_WIDTH-1:0] w_p0;
  logic signed [ACC_WIDTH-1:0]         w_y;
  logic signed [SW-1:0]                w_sum, w_sh;
  logic signed [DATA_OUT_WIDTH-1:0]    w_out;
  logic                                w_sat;
  logic                                r_valid, r_sat;
  logic signed [DATA_OUT_WIDTH-1:0]    r_data;

  // Clear drops the sample outright; it never reaches the pipeline or output.
  assign w_acc = in_valid && !clear;

  // Writes land at the clock edge, so a sample in the same cycle sees the old set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_coef <= '0;
    else if (coef_wr_en && (int'(coef_addr) < TAP_COUNT)) r_coef[coef_addr] <= coef_data;
  end

  // Last tap has nothing behind it.
  assign w_z[TAP_COUNT] = '0;

  for (genvar k = 1; k < TAP_COUNT; k++) begin : g_tap
    fir_tap #(
      .DIN_W (DATA_IN_WIDTH),
      .TAP_W (TAP_WIDTH),
      .ACC_W (ACC_WIDTH)
    ) u_tap (
      .clk     (clk),
      .reset_n (reset_n),
      .i_en    (in_valid),
      .i_clr   (clear),
      .i_x     (in_data),
      .i_h     (r_coef[k]),
      .i_z     (w_z[k+1]),
      .o_z     (w_z[k])
    );
  end

  // Tap 0 is combinational into the output register: this is what gives 1-cycle latency.
  assign w_p0  = in_data * $signed(r_coef[0]);
  assign w_y   = ACC_WIDTH'(w_p0) + $signed(w_z[1]);
  assign w_sum = $signed({w_y[ACC_WIDTH-1], w_y}) + $signed(RND);
  assign w_sh  = w_sum >>> OUT_SHIFT;

  if (DATA_OUT_WIDTH >= SW) begin : g_nosat
    assign w_sat = 1'b0;
    assign w_out = DATA_OUT_WIDTH'(w_sh);
  end else begin : g_sat
    // Fits iff every bit from the output sign bit upward agrees.
    logic [SW-DATA_OUT_WIDTH:0] w_top;
    assign w_top = w_sh[SW-1:DATA_OUT_WIDTH-1];
    assign w_sat = !((&w_top) || !(|w_top));
    assign w_out = w_sat ? (w_sh[SW-1] ? SAT_NEG : SAT_POS) : w_sh[DATA_OUT_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sat   <= 1'b0;
    end else begin
      r_valid <= w_acc;
      if (w_acc) begin
        r_data <= w_out;
        r_sat  <= w_sat;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign sat_flag  = r_sat;

endmodule

// File: tb/tb_fir_transposed_cfg.sv
// Directed bench for fir_transposed_cfg. Three configurations share one stimulus bus:
//   A: 8 taps, no shift, 40-bit out (impulse, bubbles, coef race, clear, reset)
//   B: defaults (saturation)
//   C: 6 taps, shift 1, 40-bit out (rounding, out-of-range coef address)
module tb_fir_transposed_cfg;

  logic               clk = 1'b0;
  logic               reset_n = 1'b1;
  logic               clear = 1'b0;
  logic               in_valid = 1'b0;
  logic signed [15:0] in_data = '0;
  logic               coef_wr_en = 1'b0;
  logic [2:0]         coef_addr = '0;
  logic signed [15:0] coef_data = '0;

  logic               a_vld, b_vld, c_vld, a_sat, b_sat, c_sat;
  logic signed [39:0] a_data, c_data;
  logic signed [15:0] b_data;

  always #5 clk = ~clk;

  fir_transposed_cfg #(.TAP_COUNT(8), .OUT_SHIFT(0), .DATA_OUT_WIDTH(40)) u_a (
    .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .coef_wr_en(coef_wr_en), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(a_vld), .out_data(a_data), .sat_flag(a_sat));

  fir_transposed_cfg u_b (
    .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .coef_wr_en(coef_wr_en), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(b_vld), .out_data(b_data), .sat_flag(b_sat));

  fir_transposed_cfg #(.TAP_COUNT(6), .OUT_SHIFT(1), .DATA_OUT_WIDTH(40)) u_c (
    .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .coef_wr_en(coef_wr_en), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(c_vld), .out_data(c_data), .sat_flag(c_sat));

  typedef struct {
    int     sel;   // 0=A 1=B 2=C
    bit     clr;
    bit     v;
    int     din;
    bit     ev;
    longint ed;
    bit     es;
  } vec_t;

  vec_t tv[$];
  int   seg_imp, seg_bub, seg_sat;
  int   errs = 0;
  int   checks = 0;

  function automatic void add(input int sel, input bit clr, input bit v, input int din,
                              input bit ev, input longint ed, input bit es);
    tv.push_back('{sel, clr, v, din, ev, ed, es});
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input int sel, input bit ev, input longint ed, input bit es);
    logic v, s;
    longint d;
    case (sel)
      0:       begin v = a_vld; d = a_data; s = a_sat; end
      1:       begin v = b_vld; d = b_data; s = b_sat; end
      default: begin v = c_vld; d = c_data; s = c_sat; end
    endcase
    chk({nm, ".valid"}, longint'(v), longint'(ev));
    chk({nm, ".data"},  d, ed);
    chk({nm, ".sat"},   longint'(s), longint'(es));
  endtask

  // One clock: present inputs, take the edge, settle; strobes drop afterwards.
  task automatic cyc(input bit v, input int d);
    in_valid = v;
    in_data  = 16'(d);
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    clear      = 1'b0;
    coef_wr_en = 1'b0;
  endtask

  task automatic wr(input int addr, input int data);
    coef_wr_en = 1'b1;
    coef_addr  = 3'(addr);
    coef_data  = 16'(data);
    cyc(1'b0, 0);
  endtask

  task automatic run_seg(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      clear = tv[i].clr;
      cyc(tv[i].v, tv[i].din);
      chk_out($sformatf("vec%0d", i), tv[i].sel, tv[i].ev, tv[i].ed, tv[i].es);
    end
  endtask

  initial begin
    // Impulse on A with h[k]=k+1: 1..8
    for (int k = 0; k < 8; k++) add(0, 0, 1, (k == 0) ? 1 : 0, 1, k + 1, 0);
    seg_imp = tv.size();
    // Same impulse with three idle cycles after each sample; output holds while idle
    for (int k = 0; k < 8; k++) begin
      add(0, 0, 1, (k == 0) ? 1 : 0, 1, k + 1, 0);
      for (int j = 0; j < 3; j++) add(0, 0, 0, 0, 0, k + 1, 0);
    end
    seg_bub = tv.size();
    // Saturation on B, all h=0x7FFF. One product rounds to 32766; two or more clip.
    add(1, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) add(1, 0, 1, 32767, 1, (k == 0) ? 32766 : 32767, k != 0);
    add(1, 1, 0, 0, 0, 32767, 1);
    for (int k = 0; k < 8; k++) add(1, 0, 1, -32768, 1, (k == 0) ? -32767 : -32768, k != 0);
    seg_sat = tv.size();

    // Reset state
    #1 reset_n = 1'b0;
    #1;
    chk_out("rst_a", 0, 0, 0, 0);
    chk_out("rst_b", 1, 0, 0, 0);
    chk_out("rst_c", 2, 0, 0, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    for (int k = 0; k < 8; k++) wr(k, k + 1);
    run_seg(0, seg_imp);
    run_seg(seg_imp, seg_bub);

    for (int k = 0; k < 8; k++) wr(k, 32767);
    run_seg(seg_bub, seg_sat);

    // Rounding on C: h[0]=1 only, (3+1)>>1=2, (-3+1)>>>1=-1
    reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    wr(0, 1);
    cyc(1, 3);
    chk_out("rnd_pos", 2, 1, 2, 0);
    cyc(1, -3);
    chk_out("rnd_neg", 2, 1, -1, 0);

    // Coefficient write racing a sample on A: old h[0]=1 used, then new h[0]=5
    coef_wr_en = 1'b1; coef_addr = 3'd0; coef_data = 16'sd5;
    cyc(1, 2);
    chk_out("race_old", 0, 1, 2, 0);
    cyc(1, 2);
    chk_out("race_new", 0, 1, 10, 0);

    // Out-of-range addresses on C leave h[0]=5 alone: 4*5=20 -> 10, then 0
    wr(6, 100);
    wr(7, 100);
    cyc(1, 4);
    chk_out("oor_h0", 2, 1, 10, 0);
    cyc(1, 0);
    chk_out("oor_tail", 2, 1, 0, 0);

    // Clear mid-impulse on A; a coef write in the clear cycle still lands
    clear = 1'b1;
    cyc(1'b0, 0);
    for (int k = 0; k < 8; k++) wr(k, k + 1);
    cyc(1, 1);
    chk_out("clr_y0", 0, 1, 1, 0);
    cyc(1, 0);
    chk_out("clr_y1", 0, 1, 2, 0);
    cyc(1, 0);
    chk_out("clr_y2", 0, 1, 3, 0);
    clear = 1'b1;
    coef_wr_en = 1'b1; coef_addr = 3'd0; coef_data = 16'sd2;
    cyc(1, 5);
    chk_out("clr_drop", 0, 0, 3, 0);
    for (int k = 0; k < 4; k++) begin
      cyc(1, 0);
      chk_out($sformatf("clr_zero%0d", k), 0, 1, 0, 0);
    end
    cyc(1, 1);
    chk_out("clr_wr", 0, 1, 2, 0);

    // Asynchronous reset mid-stream: outputs zero at once, coefficients gone
    cyc(1, 0);
    chk_out("pre_rst", 0, 1, 2, 0);
    #3 reset_n = 1'b0;
    #1;
    chk_out("async_a", 0, 0, 0, 0);
    chk_out("async_b", 1, 0, 0, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    cyc(1, 1);
    chk_out("post_rst0", 0, 1, 0, 0);
    cyc(1, 0);
    chk_out("post_rst1", 0, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
